// File: rtl/spi_slave_core.sv
// SPI slave front-end: pin synchronisers, CPOL/CPHA edge decode, RX deserialiser,
// TX serialiser and a per-frame first-clock flag, all in the clk domain.
module spi_slave_core #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sck,
  input  logic                      cs_n,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      miso_oe,
  input  logic [DATA_W-1:0]         tx_data,
  output logic                      tx_ack,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  output logic                      rx_abort,
  output logic                      first_clk_detected,
  output logic                      busy,
  output logic [$clog2(DATA_W)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic SCK_IDLE = (CPOL != 0);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_n_d;
  logic                   sck_s;
  logic                   cs_n_s;
  logic                   mosi_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= SCK_IDLE;
      cs_n_d    <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      cs_n_d    <= cs_n_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_n_s = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic lead_edge;
  logic trail_edge;
  logic cs_fall;
  logic cs_rise;
  logic sample_edge;
  logic shift_edge;

  assign lead_edge   = (sck_d == SCK_IDLE) && (sck_s != SCK_IDLE);
  assign trail_edge  = (sck_d != SCK_IDLE) && (sck_s == SCK_IDLE);
  assign cs_fall     = cs_n_d & ~cs_n_s;
  assign cs_rise     = ~cs_n_d & cs_n_s;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

  logic [0:0]        state;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_next;
  logic [CNT_W-1:0]  cnt_next;
  logic              word_done;
  logic              tx_hold;

  always_comb begin
    rx_next = '0;
    tx_next = '0;
    if (MSB_FIRST != 0) begin
      rx_next = {rx_sh[DATA_W-2:0], mosi_s};
      tx_next = {tx_sh[DATA_W-2:0], 1'b0};
    end else begin
      rx_next = {mosi_s, rx_sh[DATA_W-1:1]};
      tx_next = {1'b0, tx_sh[DATA_W-1:1]};
    end
    word_done = sample_edge && (bit_cnt == LAST_BIT);
    if (word_done) begin
      cnt_next = '0;
    end else if (sample_edge) begin
      cnt_next = bit_cnt + 1'b1;
    end else begin
      cnt_next = bit_cnt;
    end
  end

  assign miso = miso_oe & ((MSB_FIRST != 0) ? tx_sh[DATA_W-1] : tx_sh[0]);
  assign busy = (state == ACTIVE);

  // Handshake: tx_ack, rx_valid and rx_abort are one-cycle strobes with no
  // back-pressure; tx_data is captured on the tx_ack cycle and rx_data is
  // valid from the rx_valid cycle until the next completed word.
  // tx_hold suppresses the first shift edge after a load so bit 0 of the new
  // word stays on miso until the master has sampled it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      bit_cnt            <= '0;
      rx_sh              <= '0;
      tx_sh              <= '0;
      rx_data            <= '0;
      rx_valid           <= 1'b0;
      rx_abort           <= 1'b0;
      tx_ack             <= 1'b0;
      miso_oe            <= 1'b0;
      first_clk_detected <= 1'b0;
      tx_hold            <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_ack   <= 1'b0;
      rx_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state              <= ACTIVE;
            bit_cnt            <= '0;
            rx_sh              <= '0;
            tx_sh              <= tx_data;
            tx_ack             <= 1'b1;
            first_clk_detected <= 1'b0;
            miso_oe            <= 1'b1;
            tx_hold            <= (CPHA != 0);
          end
        end
        ACTIVE: begin
          if (lead_edge) begin
            first_clk_detected <= 1'b1;
          end
          if (sample_edge) begin
            rx_sh   <= rx_next;
            bit_cnt <= cnt_next;
            if (word_done) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
              tx_sh    <= tx_data;
              tx_ack   <= 1'b1;
              tx_hold  <= 1'b1;
            end
          end else if (shift_edge) begin
            if (tx_hold) begin
              tx_hold <= 1'b0;
            end else begin
              tx_sh <= tx_next;
            end
          end
          // A sample on the same cycle as CS release is folded in first.
          if (cs_rise) begin
            state    <= IDLE;
            miso_oe  <= 1'b0;
            bit_cnt  <= '0;
            rx_abort <= (cnt_next != '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench: one 8-bit mode-0 slave, four 16-bit slaves (one per CPOL/CPHA)
// and one 8-bit LSB-first slave, driven by a shared phase-based SPI master.
module tb_spi_slave_core;

  localparam int N = 6;

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic        sck_ph = 1'b0;
  logic        cs_n   = 1'b1;
  logic        mosi   = 1'b0;
  int          sel    = 0;
  logic [15:0] tx_word = '0;

  logic        sck_v[N];
  logic        cs_v[N];
  logic        miso_v[N];
  logic        oe_v[N];
  logic        ack_v[N];
  logic        rxv_v[N];
  logic        abort_v[N];
  logic        fcd_v[N];
  logic        busy_v[N];
  logic [15:0] rxd_v[N];
  logic [3:0]  cnt_v[N];
  logic [7:0]  rxd0;
  logic [7:0]  rxd5;
  logic [2:0]  cnt0;
  logic [2:0]  cnt5;

  int checks = 0;
  int errors = 0;
  int rxv_cnt[N];
  int ack_cnt[N];
  int abort_cnt[N];
  logic [15:0] exp_q[$];
  logic [15:0] tx_q[$];

  // clock / reset
  always #10 clk = ~clk;

  function automatic logic cpol_of(input int i);
    return (i == 3) || (i == 4);
  endfunction

  function automatic logic cpha_of(input int i);
    return (i == 2) || (i == 4);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      sck_v[i] = sck_ph ^ cpol_of(i);
      cs_v[i]  = (sel == i) ? cs_n : 1'b1;
    end
  end

  spi_slave_core #(.DATA_W(8)) u_m0 (
    .clk(clk), .rst(rst), .sck(sck_v[0]), .cs_n(cs_v[0]), .mosi(mosi),
    .miso(miso_v[0]), .miso_oe(oe_v[0]), .tx_data(tx_word[7:0]), .tx_ack(ack_v[0]),
    .rx_data(rxd0), .rx_valid(rxv_v[0]), .rx_abort(abort_v[0]),
    .first_clk_detected(fcd_v[0]), .busy(busy_v[0]), .bit_cnt(cnt0)
  );
  assign rxd_v[0] = {8'h00, rxd0};
  assign cnt_v[0] = {1'b0, cnt0};

  for (genvar g = 0; g < 4; g++) begin : g_mode
    spi_slave_core #(.DATA_W(16), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk(clk), .rst(rst), .sck(sck_v[g+1]), .cs_n(cs_v[g+1]), .mosi(mosi),
      .miso(miso_v[g+1]), .miso_oe(oe_v[g+1]), .tx_data(tx_word), .tx_ack(ack_v[g+1]),
      .rx_data(rxd_v[g+1]), .rx_valid(rxv_v[g+1]), .rx_abort(abort_v[g+1]),
      .first_clk_detected(fcd_v[g+1]), .busy(busy_v[g+1]), .bit_cnt(cnt_v[g+1])
    );
  end

  spi_slave_core #(.DATA_W(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .sck(sck_v[5]), .cs_n(cs_v[5]), .mosi(mosi),
    .miso(miso_v[5]), .miso_oe(oe_v[5]), .tx_data(tx_word[7:0]), .tx_ack(ack_v[5]),
    .rx_data(rxd5), .rx_valid(rxv_v[5]), .rx_abort(abort_v[5]),
    .first_clk_detected(fcd_v[5]), .busy(busy_v[5]), .bit_cnt(cnt5)
  );
  assign rxd_v[5] = {8'h00, rxd5};
  assign cnt_v[5] = {1'b0, cnt5};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard / pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rxv_v[i])   rxv_cnt[i]++;
      if (ack_v[i])   ack_cnt[i]++;
      if (abort_v[i]) abort_cnt[i]++;
    end
    if (rxv_v[sel] && exp_q.size() > 0) check("rx_word", rxd_v[sel], exp_q.pop_front());
    if (ack_v[sel] && tx_q.size() > 0) void'(tx_q.pop_front());
    tx_word = (tx_q.size() > 0) ? tx_q[0] : 16'h0000;
  end

  // driver tasks
  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic frame_begin(input int idx);
    sel = idx;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input int idx, input int width, input int nbits, input logic [15:0] tx_bits,
                      input bit chk_fcd, output logic [15:0] rx_bits);
    int b;
    rx_bits = '0;
    for (int k = 0; k < nbits; k++) begin
      b = (idx == 5) ? k : width - 1 - k;
      if (!cpha_of(idx)) begin
        mosi = tx_bits[b];
        half();
        rx_bits[b] = miso_v[idx];
        sck_ph = 1'b1;
        if (chk_fcd && k == 0) begin
          repeat (2) @(negedge clk);
          check("fcd_before_3clk", fcd_v[idx], 0);
          @(negedge clk);
          check("fcd_at_3clk", fcd_v[idx], 1);
          repeat (2) @(negedge clk);
        end else begin
          half();
        end
        sck_ph = 1'b0;
      end else begin
        sck_ph = 1'b1;
        mosi = tx_bits[b];
        half();
        rx_bits[b] = miso_v[idx];
        sck_ph = 1'b0;
        half();
      end
    end
  endtask

  initial begin
    logic [15:0] got;
    int rv0;
    int ak0;
    int ab0;
    int idx;

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset_outputs", {rxd_v[i], rxv_v[i], abort_v[i], ack_v[i], oe_v[i], miso_v[i],
                              busy_v[i], fcd_v[i], cnt_v[i]}, 0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // SCK activity while CS is high must be ignored
    for (int k = 0; k < 10; k++) begin
      mosi = k[0];
      sck_ph = 1'b1;
      half();
      sck_ph = 1'b0;
      half();
    end
    check("idle_sck_rxv", rxv_cnt[0] + rxv_cnt[1] + rxv_cnt[4], 0);
    check("idle_sck_cnt", cnt_v[0], 0);
    check("idle_sck_fcd", fcd_v[0], 0);
    check("idle_sck_busy", busy_v[0], 0);

    exp_q.push_back(16'h005A);
    frame_begin(0);
    xfer(0, 8, 8, 16'h005A, 1'b0, got);
    frame_end();
    check("after_idle_rx", rxd_v[0], 16'h005A);
    check("after_idle_rxv", rxv_cnt[0], 1);

    // mode 0, 0xA5 in, 0x3C out
    rv0 = rxv_cnt[0];
    ak0 = ack_cnt[0];
    tx_q.push_back(16'h003C);
    exp_q.push_back(16'h00A5);
    @(negedge clk);
    frame_begin(0);
    check("start_oe", oe_v[0], 1);
    check("start_busy", busy_v[0], 1);
    check("start_fcd_clear", fcd_v[0], 0);
    xfer(0, 8, 8, 16'h00A5, 1'b1, got);
    check("m0_miso_word", got[7:0], 8'h3C);
    frame_end();
    check("m0_rx_data", rxd_v[0], 16'h00A5);
    check("m0_rxv_pulses", rxv_cnt[0] - rv0, 1);
    check("m0_tx_acks", ack_cnt[0] - ak0, 2);
    check("m0_fcd_held", fcd_v[0], 1);
    check("m0_end_busy", busy_v[0], 0);

    // partial frame of 5 bits
    rv0 = rxv_cnt[0];
    ab0 = abort_cnt[0];
    frame_begin(0);
    xfer(0, 8, 5, 16'h00F8, 1'b0, got);
    check("partial_cnt", cnt_v[0], 5);
    frame_end();
    check("partial_abort", abort_cnt[0] - ab0, 1);
    check("partial_no_rxv", rxv_cnt[0] - rv0, 0);
    check("partial_rx_keep", rxd_v[0], 16'h00A5);
    check("partial_busy", busy_v[0], 0);
    check("partial_oe", oe_v[0], 0);
    check("partial_cnt_clr", cnt_v[0], 0);

    // all four modes, two 16-bit words per frame
    for (int g = 0; g < 4; g++) begin
      idx = g + 1;
      tx_q.push_back(16'hCAFE);
      tx_q.push_back(16'h0F0F);
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'hBEEF);
      @(negedge clk);
      frame_begin(idx);
      xfer(idx, 16, 16, 16'h1234, 1'b0, got);
      check($sformatf("mode%0d_miso_w0", g), got, 16'hCAFE);
      xfer(idx, 16, 16, 16'hBEEF, 1'b0, got);
      check($sformatf("mode%0d_miso_w1", g), got, 16'h0F0F);
      frame_end();
      check($sformatf("mode%0d_rxv", g), rxv_cnt[idx], 2);
      check($sformatf("mode%0d_acks", g), ack_cnt[idx], 3);
      check($sformatf("mode%0d_abort", g), abort_cnt[idx], 0);
      check($sformatf("mode%0d_rx_last", g), rxd_v[idx], 16'hBEEF);
    end

    // reset after 4 bits, then a clean 0xC3 frame
    rv0 = rxv_cnt[0];
    ab0 = abort_cnt[0];
    frame_begin(0);
    xfer(0, 8, 4, 16'h00C3, 1'b0, got);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_outputs", {rxd_v[0], rxv_v[0], abort_v[0], ack_v[0], oe_v[0], miso_v[0],
                             busy_v[0], fcd_v[0], cnt_v[0]}, 0);
    cs_n = 1'b1;
    sck_ph = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_abort", abort_cnt[0] - ab0, 0);
    check("midrst_no_rxv", rxv_cnt[0] - rv0, 0);
    exp_q.push_back(16'h00C3);
    frame_begin(0);
    xfer(0, 8, 8, 16'h00C3, 1'b0, got);
    frame_end();
    check("post_rst_rx", rxd_v[0], 16'h00C3);
    check("post_rst_rxv", rxv_cnt[0] - rv0, 1);

    // LSB-first slave
    tx_q.push_back(16'h002D);
    exp_q.push_back(16'h0001);
    @(negedge clk);
    frame_begin(5);
    xfer(5, 8, 8, 16'h0001, 1'b0, got);
    check("lsb_first_miso_bit", got[0], 1);
    check("lsb_miso_word", got[7:0], 8'h2D);
    frame_end();
    check("lsb_rx_data", rxd_v[5], 16'h0001);
    check("lsb_rxv", rxv_cnt[5], 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
Parametrised SPI slave front-end. It supersedes the single first-edge detector with a full mode-configurable slave. It synchronises SCK/CS_N/MOSI into the clk domain and detects SCK edges per CPOL/CPHA. It deserialises DATA_W-bit words to a valid-pulse interface, serialises a TX word onto MISO, and keeps a per-frame first-clock flag. It sits between the board SPI pins and the register/command logic.

Parameters:
DATA_W, 8, word width in bits (2..32)
SYNC_STAGES, 2, synchroniser depth for sck/cs_n/mosi (2..4)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing
MSB_FIRST, 1, 1 = MSB first on both MOSI and MISO; 0 = LSB first

Ports:
clk  input  1  system clock, must be at least 4x SCK frequency
rst  input  1  reset, asynchronous, active-high
sck  input  1  SPI clock (async)
cs_n  input  1  chip select, active-low (async)
mosi  input  1  master-out data (async)
miso  output  1  slave-out data
miso_oe  output  1  MISO tristate enable, high while frame active
tx_data  input  DATA_W  next word to transmit
tx_ack  output  1  1-cycle pulse: tx_data captured into TX shifter
rx_data  output  DATA_W  last complete received word
rx_valid  output  1  1-cycle pulse: rx_data updated
rx_abort  output  1  1-cycle pulse: frame ended with partial word (bit_cnt != 0)
first_clk_detected  output  1  sticky: first leading SCK edge seen in current frame
busy  output  1  frame active (state ACTIVE)
bit_cnt  output  $clog2(DATA_W)  bits sampled in current word

Behaviour:
- Reset (async): all outputs 0; miso=0, miso_oe=0; synchroniser flops 0, except the sck chain, which resets to CPOL. cs_n chain resets to 1. State IDLE, shifters 0.
- Synchroniser: SYNC_STAGES flops per input, plus one history flop on sck_s and cs_n_s for edge detect. Leading edge = sck_s leaves CPOL; trailing edge = sck_s returns to CPOL.
- Input-to-action latency: SYNC_STAGES+1 clk cycles after a pin transition.
- FSM states: IDLE and ACTIVE.
- IDLE -> ACTIVE on cs_n_s falling edge, in the same cycle:
  - bit_cnt=0
  - TX shifter loaded from tx_data; tx_ack pulses
  - first_clk_detected cleared
  - miso_oe=1
  - miso = first TX bit (MSB if MSB_FIRST), valid before the first SCK edge
- ACTIVE -> IDLE on cs_n_s rising edge:
  - miso_oe=0, busy=0
  - rx_abort pulses if bit_cnt != 0
  - partial word discarded; rx_data unchanged
  - first_clk_detected held until the next frame start
- SCK edges are ignored in IDLE.
- first_clk_detected: set on the first leading edge in ACTIVE; stays 1 for the rest of the frame.
- Sample edge (leading if CPHA=0, trailing if CPHA=1):
  - mosi_s shifted into the RX shifter; bit_cnt increments
  - when bit_cnt == DATA_W-1: rx_data <= completed word and rx_valid=1 on the same clk edge; bit_cnt wraps to 0; TX shifter reloads from tx_data with a tx_ack pulse
- Shift edge (the other edge) advances the TX shifter; miso presents the next bit.
  - CPHA=1: the first leading edge of each word presents bit 0 of the freshly loaded word; no shift occurs before it.
  - CPHA=0: the trailing edge following the last sample of a word presents the first bit of the reloaded word.
- Back-to-back words within one frame run without gaps. rx_valid pulses never merge: minimum spacing between pulses is 2*DATA_W sync'd edges.
- Simultaneous cs_n_s rise and sample edge in the same cycle: the sample edge is processed first. If it completes the word, rx_valid=1 and rx_abort=0; then the FSM goes to IDLE.
- Simultaneous cs_n_s fall and an SCK edge: only the frame start is processed; that SCK edge is ignored.
- Glitch-free: outputs change only on clk rising edges. rx_valid, tx_ack and rx_abort are each high for exactly one cycle.
- Reset mid-frame: immediate return to IDLE. No rx_valid or rx_abort is emitted for the aborted frame.

Test Plan:
- Mode 0, DATA_W=8, clk=50 MHz, SCK=5 MHz:
  - master sends 0xA5 while tx_data=0x3C
  - required: rx_data=0xA5 with one rx_valid pulse
  - required: MISO bits observed by master = 0x3C; first_clk_detected=1 from the first rising SCK edge (+3 clk)
- All four CPOL/CPHA combinations, 16-bit words:
  - master sends 0x1234 then 0xBEEF in one frame
  - required: two rx_valid pulses with rx_data 0x1234 then 0xBEEF
  - required: master receives tx_data values 0xCAFE and 0x0F0F, presented at the corresponding tx_ack pulses
- Partial frame: CS low, 5 SCK cycles, CS high:
  - required: rx_abort pulses once, no rx_valid, rx_data unchanged, busy=0, miso_oe=0
- SCK toggling with CS high:
  - required: no rx_valid, bit_cnt=0, first_clk_detected=0
  - a subsequent frame still decodes 0x5A correctly
- Assert rst after 4 bits of a frame, release, run a new frame of 0xC3:
  - required: all outputs 0 during reset, no pulses for the aborted frame
  - required: rx_data=0xC3 on the new frame
- MSB_FIRST=0, send 0x01:
  - required: rx_data=0x01 when the first MOSI bit is 1
  - required: MISO carries tx_data bit 0 first
